// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: 2-flop sync, shared sample tick, N-sample accept.
// Optional typematic auto-repeat on oPress when DEBOUNCE_REPEAT_EN is defined.
`timescale 1ns/1ps
module debouncer_multi #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 12500,
  parameter int STABLE_CNT   = 4,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [CHANNELS-1:0] iButton,
  output logic [CHANNELS-1:0] oButton,
  output logic [CHANNELS-1:0] oPress,
  output logic [CHANNELS-1:0] oRelease,
  output logic                oAny,
  output logic                oTick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] samp;
  logic [DW-1:0]       div_q, div_d;
  logic                tick;
  logic                tick_q;
  logic [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0] btn_q, btn_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] rel_q, rel_d;
  logic [CHANNELS-1:0] acc_press;
  logic [CHANNELS-1:0] rpt_press;

  assign samp = sync2_q ^ {CHANNELS{ACTIVE_LOW != 0}};

  // Prescaler: wrap at TICK_DIV-1, tick on the last count
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DW'(1);
  end

  // Stability counters: accept a change after STABLE_CNT differing ticks
  always_comb begin
    cnt_d     = cnt_q;
    btn_d     = btn_q;
    acc_press = '0;
    rel_d     = '0;
    if (tick) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (samp[i] == btn_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          btn_d[i]     = samp[i];
          cnt_d[i]     = '0;
          acc_press[i] = samp[i];
          rel_d[i]     = ~samp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                     : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RATE = RW'(REPEAT_RATE);

  logic [CHANNELS-1:0][RW-1:0] rep_q, rep_d;
  logic [CHANNELS-1:0]         arm_q, arm_d;
  logic [RW-1:0]               rep_nx;

  // Repeat timer: first pulse after REPEAT_DELAY ticks, then every REPEAT_RATE
  always_comb begin
    rep_d     = rep_q;
    arm_d     = arm_q;
    rpt_press = '0;
    rep_nx    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rep_nx = rep_q[i] + RW'(1);
      if (!btn_q[i] || (btn_d[i] != btn_q[i])) begin
        rep_d[i] = '0;
        arm_d[i] = 1'b0;
      end else if (tick) begin
        if (rep_nx == (arm_q[i] ? R_RATE : R_DLY)) begin
          rpt_press[i] = 1'b1;
          rep_d[i]     = '0;
          arm_d[i]     = 1'b1;
        end else begin
          rep_d[i] = rep_nx;
        end
      end
    end
  end

  // Repeat state registers
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rep_q <= '0;
      arm_q <= '0;
    end else begin
      rep_q <= rep_d;
      arm_q <= arm_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = (REPEAT_DELAY + REPEAT_RATE) != 0;
  assign rpt_press     = '0;
`endif

  assign press_d = acc_press | rpt_press;

  // Main state: synchroniser, prescaler, counters and registered outputs
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
      btn_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      sync1_q <= iButton;
      sync2_q <= sync1_q;
      div_q   <= div_d;
      tick_q  <= tick;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign oButton  = btn_q;
  assign oPress   = press_q;
  assign oRelease = rel_q;
  assign oAny     = |btn_q;
  assign oTick    = tick_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi with a pulse scoreboard.
// Repeat checks are built when DEBOUNCE_REPEAT_EN is defined.
`timescale 1ns/1ps
module tb_debouncer_multi;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int SC = 3;

  logic          iClk = 1'b0;
  logic          iRst;
  logic [CH-1:0] iButton;
  logic [CH-1:0] oButton, oPress, oRelease;
  logic          oAny, oTick;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       rel;
    logic [7:0] ch;
  } ev_t;

  ev_t           exp_q[$];
  logic [CH-1:0] prev = '0;

  always #5 iClk = ~iClk;

  debouncer_multi #(
    .CHANNELS(CH), .TICK_DIV(TD), .STABLE_CNT(SC), .ACTIVE_LOW(0),
    .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iButton(iButton),
    .oButton(oButton), .oPress(oPress), .oRelease(oRelease),
    .oAny(oAny), .oTick(oTick)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(string tag, int v, int lo, int hi);
    tests++;
    assert (v >= lo && v <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic push(logic rel, int ch);
    ev_t e;
    e.rel = rel;
    e.ch  = 8'(ch);
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(logic rel, int ch);
    ev_t e;
    tests++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL sb_spurious: observed pulse rel=%0d ch=%0d expected none",
             rel, ch);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_ch", 32'(ch), 32'(e.ch));
      check("sb_kind", 32'(rel), 32'(e.rel));
    end
  endtask

  task automatic wait_btn(int ch, logic v, output int lat);
    lat = 0;
    while (oButton[ch] !== v && lat < 40) begin
      @(negedge iClk);
      lat++;
    end
    check($sformatf("btn%0d_reach", ch), 32'(oButton[ch]), 32'(v));
  endtask

`ifdef DEBOUNCE_REPEAT_EN
  task automatic wait_press(int ch, output int lat);
    lat = 0;
    do begin
      @(negedge iClk);
      lat++;
    end while (oPress[ch] !== 1'b1 && lat < 40);
  endtask
`endif

  always @(negedge iClk) begin
    if (!iRst) begin
      prev <= '0;
    end else begin
      check("any", 32'(oAny), 32'(|oButton));
`ifndef DEBOUNCE_REPEAT_EN
      check("press_edge", 32'(oPress), 32'(oButton & ~prev));
`endif
      check("release_edge", 32'(oRelease), 32'(~oButton & prev));
      for (int c = 0; c < CH; c++) begin
        if (oPress[c])   sb_pop(1'b0, c);
        if (oRelease[c]) sb_pop(1'b1, c);
      end
      prev <= oButton;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   n;
    int   g;
    logic seen;
    iRst    = 1'b0;
    iButton = '0;
    repeat (3) @(negedge iClk);
    check("rst_btn", 32'(oButton), 0);
    check("rst_press", 32'(oPress), 0);
    check("rst_rel", 32'(oRelease), 0);
    check("rst_any", 32'(oAny), 0);
    check("rst_tick", 32'(oTick), 0);
    #1 iRst = 1'b1;
    lat = 0;
    do begin
      @(negedge iClk);
      lat++;
    end while (oTick !== 1'b1 && lat < 20);
    check("first_tick", 32'(lat), 32'(TD));

    // clean press and release on ch0
    #1 iButton = 4'b0001;
    push(1'b0, 0);
    wait_btn(0, 1'b1, lat);
    check_rng("t1_lat", lat, 11, 15);
    check("t1_press", 32'(oPress[0]), 1);
    check("t1_others", 32'(oButton[3:1]), 0);
    check("t1_any", 32'(oAny), 1);
    @(negedge iClk);
    check("t1_press_1cyc", 32'(oPress[0]), 0);
    #1 iButton = 4'b0000;
    push(1'b1, 0);
    wait_btn(0, 1'b0, lat);
    check_rng("t1_rel_lat", lat, 11, 15);
    check("t1_rel", 32'(oRelease[0]), 1);

    // bounce on ch1
    repeat (2) @(negedge iClk);
    #1;
    for (int k = 0; k < 14; k++) begin
      iButton[1] = ~iButton[1];
      repeat (3) @(negedge iClk);
      #1;
    end
    repeat (8) @(negedge iClk);
    check("t2_bounce", 32'(oButton[1]), 0);
    #1 iButton[1] = 1'b1;
    push(1'b0, 1);
    wait_btn(1, 1'b1, lat);
    check_rng("t2_lat", lat, 11, 15);
    #1 iButton[1] = 1'b0;
    push(1'b1, 1);
    wait_btn(1, 1'b0, lat);
    check_rng("t2_rel_lat", lat, 11, 15);

    // short glitch on ch2
    #1 iButton[2] = 1'b1;
    repeat (6) @(negedge iClk);
    #1 iButton[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 26; k++) begin
      @(negedge iClk);
      seen = seen | oButton[2] | oPress[2] | oRelease[2];
    end
    check("t3_glitch", 32'(seen), 0);

    // simultaneous press on ch2/ch3, release ch3 only
    #1 iButton = 4'b1100;
    push(1'b0, 2);
    push(1'b0, 3);
    wait_btn(2, 1'b1, lat);
    check("t4_sim_press", 32'(oPress), 32'(4'b1100));
    #1 iButton = 4'b0100;
    push(1'b1, 3);
    wait_btn(3, 1'b0, lat);
    check("t4_rel3", 32'(oRelease), 32'(4'b1000));
    check("t4_hold2", 32'(oButton), 32'(4'b0100));
    #1 iButton = 4'b0000;
    push(1'b1, 2);
    wait_btn(2, 1'b0, lat);

    // reset in the middle of a count
    #1 iButton[0] = 1'b1;
    repeat (3) @(negedge iClk);
    n = 0;
    g = 0;
    while (n < 2 && g < 40) begin
      @(negedge iClk);
      g++;
      if (oTick) n++;
    end
    check("t5_ticks", 32'(n), 2);
    check("t5_pre", 32'(oButton[0]), 0);
    #1 iRst = 1'b0;
    #1;
    check("t5_rst_btn", 32'(oButton), 0);
    check("t5_rst_pulse", 32'({oPress, oRelease}), 0);
    check("t5_rst_misc", 32'({oAny, oTick}), 0);
    repeat (2) @(negedge iClk);
    #1 iRst = 1'b1;
    push(1'b0, 0);
    wait_btn(0, 1'b1, lat);
    check("t5_lat", 32'(lat), 32'(SC * TD));
    check("t5_press", 32'(oPress[0]), 1);

`ifdef DEBOUNCE_REPEAT_EN
    // auto-repeat while ch0 held
    push(1'b0, 0);
    wait_press(0, lat);
    check("t6_first_rpt", 32'(lat), 20);
    push(1'b0, 0);
    wait_press(0, lat);
    check("t6_rpt2", 32'(lat), 8);
    #1 iButton[0] = 1'b0;
    push(1'b0, 0);
    push(1'b1, 0);
    wait_press(0, lat);
    check("t6_rpt3", 32'(lat), 8);
    wait_btn(0, 1'b0, lat);
    check("t6_rel_lat", 32'(lat), 4);
    check("t6_rel_nopress", 32'({oPress[0], oRelease[0]}), 1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge iClk);
      seen = seen | oPress[0];
    end
    check("t6_no_rpt", 32'(seen), 0);
`else
    #1 iButton[0] = 1'b0;
    push(1'b1, 0);
    wait_btn(0, 1'b0, lat);
    check_rng("t5_rel_lat", lat, 11, 15);
`endif

    repeat (8) @(negedge iClk);
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
